// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the async FIFO read-side word packer.
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int LANES_DEF = 4;

    typedef enum logic [1:0] {FILL, FULL, FLUSH} pack_state_t;

endpackage

// File: rtl/pack_obuf.sv
// Output register stage of the word packer: holds one word until the consumer takes it.
module pack_obuf #(
    parameter int W  = 32,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  word,
    input  logic [CW-1:0] cnt,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_cnt,
    output logic [15:0]   words_out,
    output logic          free
);

    // Handshake: a word is taken on any rising edge where out_valid && out_ready.
    // The payload never changes while out_valid=1 and out_ready=0, because
    // load is only raised when free is high.
    assign free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            words_out <= '0;
        end else begin
            if (load) begin
                out_data  <= word;
                out_cnt   <= cnt;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) begin
                words_out <= words_out + 16'd1;
            end
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops show-ahead FIFO entries and packs LANES of them into one wide word;
// flush emits a partially filled word so a burst tail is never stranded.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic                         rclk,
    input  logic                         rrst,
    input  logic [DSIZE-1:0]             rdata,
    input  logic                         rempty,
    output logic                         rinc,
    input  logic                         flush,
    output logic [DSIZE*LANES-1:0]       out_data,
    output logic [$clog2(LANES+1)-1:0]   out_cnt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  words_out
);

    localparam int CW = $clog2(LANES+1);
    localparam int W  = DSIZE * LANES;
    localparam logic [CW-1:0] FULL_CNT = CW'(LANES);

    pack_state_t   state;
    logic [CW-1:0] n;
    logic [CW-1:0] n_inc;
    logic [W-1:0]  acc;
    logic          load;
    logic          free;
    logic [CW-1:0] load_cnt;

    assign rinc     = (state == FILL) && !rempty && !rrst;
    assign n_inc    = n + CW'(1);
    assign load     = (state != FILL) && free;
    assign load_cnt = (state == FULL) ? FULL_CNT : n;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state <= FILL;
            n     <= '0;
            acc   <= '0;
        end else begin
            case (state)
                FILL: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (rinc && n == CW'(i)) begin
                            acc[i*DSIZE +: DSIZE] <= rdata;
                        end
                    end
                    if (rinc) begin
                        n <= n_inc;
                    end
                    // A flush on the edge that completes the word is absorbed by FULL.
                    if (rinc && n_inc == FULL_CNT) begin
                        state <= FULL;
                    end else if (flush && (rinc || n != '0)) begin
                        state <= FLUSH;
                    end
                end
                FULL, FLUSH: begin
                    // Clearing acc here is what keeps unused lanes of a flushed word zero.
                    if (free) begin
                        acc   <= '0;
                        n     <= '0;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    pack_obuf #(
        .W  (W),
        .CW (CW)
    ) u_obuf (
        .clk       (rclk),
        .rst       (rrst),
        .load      (load),
        .word      (acc),
        .cnt       (load_cnt),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .words_out (words_out),
        .free      (free)
    );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-based FIFO model, expected-word scoreboard, directed and random phases.
module tb_fifo_word_packer;

    logic        clk = 1'b0;
    logic        rrst;
    logic [7:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic        flush;
    logic [31:0] out_data;
    logic [2:0]  out_cnt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] words_out;

    logic [7:0]  fifo_q[$];
    logic [34:0] exp_q[$];
    int          exp_total = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          prod_done;

    fifo_word_packer #(.DSIZE(8), .LANES(4)) dut (
        .rclk      (clk),
        .rrst      (rrst),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .flush     (flush),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? 8'h00 : fifo_q[0];
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] c);
        exp_q.push_back({c, d});
        exp_total++;
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || out_valid) && k < 2000) begin
            cyc(1);
            k++;
        end
        chk({tag, "_drain_in_time"}, (k < 2000), 1);
        chk({tag, "_words_out"}, words_out, exp_total);
    endtask

    // FIFO model: pops on an edge where the packer strobes rinc, show-ahead head.
    always @(posedge clk) begin
        if (rinc) void'(fifo_q.pop_front());
        #1 refresh();
    end

    // Scoreboard: each accepted word must match the next expected word.
    always @(negedge clk) begin
        logic [34:0] e;
        if (!rrst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("word_data", out_data, e[31:0]);
                chk("word_cnt", out_cnt, e[34:32]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mq[$];
        logic [7:0] b;
        int         pushed;

        rrst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        refresh();
        cyc(2);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_cnt", out_cnt, 0);
        chk("rst_words", words_out, 0);
        chk("rst_rinc", rinc, 0);
        cyc(1);
        rrst = 1'b0;
        cyc(1);

        // Full word, latency and out_valid drop.
        out_ready = 1'b1;
        expect_word(32'h44332211, 3'd4);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        cyc(4);
        @(negedge clk);
        chk("lat_not_yet", out_valid, 0);
        cyc(1);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        cyc(1);
        @(negedge clk);
        chk("valid_drop", out_valid, 0);
        cyc(1);
        wait_drain("t1");

        // Flush of a partial word, next entry lands in lane 0.
        expect_word(32'h0000B2A1, 3'd2);
        expect_word(32'hF6E5D4C3, 3'd4);
        push(8'hA1); push(8'hB2);
        cyc(3);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(3);
        push(8'hC3); push(8'hD4); push(8'hE5); push(8'hF6);
        wait_drain("t2");

        // Backpressure: first word held, FIFO keeps four entries.
        out_ready = 1'b0;
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        expect_word(32'h0C0B0A09, 3'd4);
        for (int i = 1; i <= 12; i++) push(8'(i));
        cyc(20);
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, 32'h04030201);
        chk("hold_cnt", out_cnt, 4);
        chk("hold_rinc", rinc, 0);
        chk("hold_fifo_level", fifo_q.size(), 4);
        cyc(5);
        @(negedge clk);
        chk("hold_data_later", out_data, 32'h04030201);
        cyc(1);
        out_ready = 1'b1;
        wait_drain("t3");

        // Flush with nothing accumulated: dropped.
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(5);
        @(negedge clk);
        chk("flush_empty_no_word", out_valid, 0);
        cyc(1);
        wait_drain("t4a");

        // Flush on the edge of the 4th pop: absorbed, single full word.
        expect_word(32'h34333231, 3'd4);
        push(8'h31); push(8'h32); push(8'h33);
        cyc(4);
        push(8'h34);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        wait_drain("t4b");

        // Flush on the edge of the 2nd pop: popped entry is included.
        expect_word(32'h00004241, 3'd2);
        push(8'h41);
        cyc(3);
        push(8'h42);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        wait_drain("t4c");

        // Reset while a word is held: nothing emitted afterwards.
        out_ready = 1'b0;
        expect_word(32'h74737271, 3'd4);
        push(8'h71); push(8'h72); push(8'h73); push(8'h74);
        cyc(8);
        rrst = 1'b1;
        exp_q.delete();
        exp_total = 0;
        @(negedge clk);
        chk("rst_hs_valid", out_valid, 0);
        chk("rst_hs_data", out_data, 0);
        chk("rst_hs_words", words_out, 0);
        cyc(1);
        rrst = 1'b0;
        out_ready = 1'b1;
        cyc(10);
        wait_drain("t5a");

        // Reset after 3 pops: partial word discarded, fresh word follows.
        push(8'h51); push(8'h52); push(8'h53);
        cyc(4);
        rrst = 1'b1;
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        exp_q.delete();
        exp_total = 0;
        @(negedge clk);
        chk("rst_mid_rinc", rinc, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_cnt", out_cnt, 0);
        chk("rst_mid_words", words_out, 0);
        chk("rst_mid_fifo_level", fifo_q.size(), 4);
        expect_word(32'h64636261, 3'd4);
        cyc(1);
        rrst = 1'b0;
        wait_drain("t5b");

        // Random stream of 70 words with random backpressure.
        rrst = 1'b1;
        exp_q.delete();
        exp_total = 0;
        cyc(1);
        rrst = 1'b0;
        cyc(1);
        prod_done = 1'b0;
        pushed = 0;
        fork
            begin
                while (pushed < 280) begin
                    int burst = $urandom_range(0, 2);
                    for (int j = 0; j < burst && pushed < 280; j++) begin
                        b = 8'($urandom_range(0, 255));
                        mq.push_back(b);
                        if (mq.size() == 4) begin
                            expect_word({mq[3], mq[2], mq[1], mq[0]}, 3'd4);
                            mq.delete();
                        end
                        push(b);
                        pushed++;
                    end
                    cyc(1);
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    cyc(1);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("rand");
        chk("rand_words_out_70", words_out, 70);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
